aes_batch_sched: RTL and testbench
==================================

Name: aes_batch_sched

Overview:
Batch scheduler in front of the N-lane parallel AES_top core.
- Collects single 128-bit plaintext/key blocks from one valid/ready stream into N lane registers.
- Launches the core once per batch and waits for done.
- Returns ciphertexts one at a time, in arrival order, with each block's tag.
- A flush input launches a partial batch. A watchdog aborts a batch whose done never arrives.

Parameters:
N, 10, number of AES lanes; must match the AES_top instance.
TAG_W, 8, width of the per-block tag carried alongside each block.
TIMEOUT, 1023, maximum WAIT cycles before abort; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input block valid.
in_ready  out  1  scheduler can accept an input block.
in_plain  in  128  plaintext block.
in_key  in  128  cipher key for this block.
in_tag  in  TAG_W  opaque tag, returned with the result.
flush  in  1  launch the currently buffered partial batch.
aes_start  out  1  one-cycle launch pulse to AES_top.
aes_plain  out  128*N  lane plaintexts; lane i at bits [128*i +: 128].
aes_key  out  128*N  lane keys, same packing.
aes_done  in  1  AES_top batch-complete pulse.
aes_cipher  in  128*N  AES_top lane ciphertexts, same packing.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_cipher  out  128  ciphertext.
out_tag  out  TAG_W  tag of the result.
busy  out  1  high in every state except FILL with cnt==0.
timeout_err  out  1  sticky; set on watchdog abort; cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, except in_ready=1 once rst deasserts.
  - State=FILL; cnt=0; lane, tag and result registers zeroed.
  - rst mid-batch discards the batch; no partial output.
- FILL:
  - in_ready = (cnt<N).
  - On in_valid&&in_ready, the block is written to lane cnt and its tag to tag[cnt]; cnt increments.
  - Go to LAUNCH when cnt becomes N.
  - Go to LAUNCH when flush is high and cnt (after any same-cycle accept) is >0. A block accepted in the flush cycle belongs to the batch.
  - flush with cnt==0 and no accept is ignored.
- LAUNCH:
  - aes_start=1 for exactly one cycle; in_ready=0; next state WAIT.
  - Lanes >=cnt drive all-zero plaintext/key. Their results are discarded.
  - aes_plain and aes_key are held stable from LAUNCH until leaving WAIT.
- WAIT:
  - in_ready=0; the watchdog counter increments each cycle from 0.
  - On aes_done: capture aes_cipher into the result registers; go to DRAIN with ptr=0.
  - If the watchdog reaches TIMEOUT without aes_done: set timeout_err, discard the batch, cnt=0, go to FILL.
  - If aes_done arrives in the same cycle the watchdog reaches TIMEOUT, done wins.
  - aes_done is ignored in every state except WAIT.
- DRAIN:
  - out_valid=1.
  - out_cipher = result lane ptr; out_tag = tag[ptr].
  - On out_ready: ptr increments. When ptr==cnt-1 is accepted: cnt=0, go to FILL. in_ready rises the next cycle.
  - While out_ready=0, out_valid, out_cipher and out_tag hold stable.
- Output path latency: result lane 0 is presented the cycle after aes_done is sampled.
- Ordering: results leave in exactly the order blocks were accepted, including across partial batches.
- Counters: cnt and ptr are $clog2(N+1) bits wide. The watchdog is $clog2(TIMEOUT+1) bits wide and saturates; it does not wrap.

Test Plan:
1. Full batch, N=10:
   - Stimulus: 10 back-to-back FIPS-197 blocks (pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f), tags 0..9; model returns done 12 cycles after start.
   - Required: single aes_start pulse; 10 outputs of 69c4e0d86a7b0430d8cdb78070b4c55a with tags 0..9 in order; in_ready low throughout LAUNCH/WAIT/DRAIN.
2. Partial flush:
   - Stimulus: 3 blocks, then flush.
   - Required: aes_start occurs; lanes 3..9 of aes_plain/aes_key are zero; exactly 3 outputs with tags 0,1,2; next batch refills from lane 0.
3. Flush with same-cycle accept:
   - Stimulus: flush asserted together with the 5th accepted block.
   - Required: batch of 5, 5 outputs.
   - Stimulus: flush with cnt==0.
   - Required: no aes_start.
4. Back-pressure:
   - Stimulus: out_ready toggled randomly at ~30% high during DRAIN.
   - Required: out_cipher and out_tag stable while out_valid&&!out_ready; no loss or duplication; all 10 results in order.
5. Timeout:
   - Stimulus: model never asserts done, TIMEOUT=1023.
   - Required: timeout_err rises after 1023 WAIT cycles; no out_valid; in_ready=1 next cycle.
   - Stimulus: stray aes_done later, in FILL.
   - Required: ignored.
6. Reset mid-operation:
   - Stimulus: rst asserted during DRAIN after 4 of 10 outputs.
   - Required: all outputs immediately 0 (async); timeout_err cleared; after release, a fresh 10-block batch completes correctly.

Source files
------------

// File: rtl/aes_batch_sched.sv
// Purpose : gathers single plaintext/key blocks into N AES lanes, fires the core once per batch, returns results in order.
// Latency : result lane 0 appears the cycle after aes_done; a batch launches the cycle after it fills or is flushed.
// Backpressure: in_ready drops while a batch is in flight or draining; out_valid/out_cipher/out_tag hold while out_ready=0.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_plain/in_key/in_tag   block input stream
//   flush                          launch the buffered partial batch
//   aes_start/aes_plain/aes_key    launch pulse and lane operands to AES_top
//   aes_done/aes_cipher            completion pulse and lane results from AES_top
//   out_valid/out_ready/out_cipher/out_tag     result stream, arrival order
//   busy, timeout_err              status; timeout_err is sticky until rst
module aes_batch_sched #(
  parameter int N       = 10,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_plain,
  input  logic [127:0]       in_key,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               aes_start,
  output logic [128*N-1:0]   aes_plain,
  output logic [128*N-1:0]   aes_key,
  input  logic               aes_done,
  input  logic [128*N-1:0]   aes_cipher,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_cipher,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      ptr;
  logic [WW-1:0]      wdog;
  logic               timeout_err_q;
  logic [127:0]       lane_plain [N];
  logic [127:0]       lane_key   [N];
  logic [127:0]       result     [N];
  logic [TAG_W-1:0]   tag        [N];

  logic               accept;
  logic [CW-1:0]      cnt_inc;
  logic [CW-1:0]      cnt_acc;
  logic               wdog_expire;
  logic               drain_last;

  assign accept      = (state == FILL) && in_valid && in_ready;
  assign cnt_inc     = cnt + 1'b1;
  // Occupancy after this cycle's accept; a block arriving with flush joins the batch.
  assign cnt_acc     = accept ? cnt_inc : cnt;
  // The cycle in which the watchdog would reach TIMEOUT.
  assign wdog_expire = (wdog == WW'(TIMEOUT - 1));
  assign drain_last  = out_ready && (ptr == cnt - 1'b1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if ((cnt_acc == CW'(N)) || (flush && (cnt_acc != '0)))
          state_nxt = LAUNCH;
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        // done takes priority over a same-cycle watchdog expiry
        if (aes_done)         state_nxt = DRAIN;
        else if (wdog_expire) state_nxt = FILL;
      end
      DRAIN: begin
        if (drain_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    aes_start  = (state == LAUNCH);
    out_valid  = (state == DRAIN);
    // Held low during reset itself so nothing is accepted before release.
    in_ready   = !rst && (state == FILL) && (cnt < CW'(N));
    busy       = !((state == FILL) && (cnt == '0));
    out_cipher = out_valid ? result[ptr] : '0;
    out_tag    = out_valid ? tag[ptr]    : '0;
    aes_plain  = '0;
    aes_key    = '0;
    // Lanes beyond the batch present zeros; stale lanes from older batches never leak.
    for (int i = 0; i < N; i++) begin
      if (i < int'(cnt)) begin
        aes_plain[128*i +: 128] = lane_plain[i];
        aes_key[128*i +: 128]   = lane_key[i];
      end
    end
  end

  assign timeout_err = timeout_err_q;

  // Datapath: lanes, tags, results, counters, watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      ptr           <= '0;
      wdog          <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        lane_plain[i] <= '0;
        lane_key[i]   <= '0;
        result[i]     <= '0;
        tag[i]        <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            lane_plain[cnt] <= in_plain;
            lane_key[cnt]   <= in_key;
            tag[cnt]        <= in_tag;
            cnt             <= cnt_inc;
          end
        end
        LAUNCH: begin
          wdog <= '0;
          ptr  <= '0;
        end
        WAIT: begin
          if (aes_done) begin
            for (int i = 0; i < N; i++)
              result[i] <= aes_cipher[128*i +: 128];
            ptr <= '0;
          end else if (wdog_expire) begin
            timeout_err_q <= 1'b1;
            cnt           <= '0;
          end else if (wdog != WW'(TIMEOUT)) begin
            wdog <= wdog + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (drain_last) begin
              cnt <= '0;
              ptr <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_batch_sched.sv
module tb_aes_batch_sched;

  localparam int N       = 10;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 1023;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [127:0]       in_plain = '0;
  logic [127:0]       in_key = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               flush = 1'b0;
  logic               aes_start;
  logic [128*N-1:0]   aes_plain;
  logic [128*N-1:0]   aes_key;
  logic               aes_done = 1'b0;
  logic [128*N-1:0]   aes_cipher = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [127:0]       out_cipher;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;
  logic               timeout_err;

  aes_batch_sched #(.N(N), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_plain(in_plain), .in_key(in_key), .in_tag(in_tag),
    .flush(flush),
    .aes_start(aes_start), .aes_plain(aes_plain), .aes_key(aes_key),
    .aes_done(aes_done), .aes_cipher(aes_cipher),
    .out_valid(out_valid), .out_ready(out_ready), .out_cipher(out_cipher), .out_tag(out_tag),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     ct;
  } exp_t;

  exp_t         sb[$];        // expected results in acceptance order
  logic [127:0] bq_plain[$];  // blocks of the batch being filled
  logic [127:0] bq_key[$];

  int n_pop = 0;
  int n_start = 0;
  int last_start_cyc = 0;
  int done_delay = 12;
  int rdy_pct = 100;
  bit done_en = 1'b1;
  bit in_flight = 1'b0;
  bit stray_req = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stand-in for AES_top: the real FIPS-197 vector, otherwise a keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
    if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return (p ^ {k[63:0], k[127:64]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Downstream back-pressure
  initial forever begin
    @(posedge clk);
    #1 out_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Result monitor / scoreboard
  initial begin : monitor
    bit stall;
    logic [127:0] pc;
    logic [TAG_W-1:0] pt;
    exp_t e;
    stall = 1'b0;
    pc = '0;
    pt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (aes_start || out_valid || (in_flight && !timeout_err))
          chk("in_ready_low_busy", in_ready, 0);
        if (stall)
          chk("out_hold", {out_valid, out_tag, out_cipher}, {1'b1, pt, pc});
        if (out_valid) begin
          chk("out_expected", sb.size() != 0, 1);
          if (out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("out", {out_tag, out_cipher}, {e.tag, e.ct});
            n_pop++;
          end
        end
        stall = out_valid && !out_ready;
        pc = out_cipher;
        pt = out_tag;
      end
    end
  end

  // AES_top model
  initial begin : core
    logic [127:0] ct [N];
    logic [128*N-1:0] cap_p;
    logic [127:0] ep;
    logic [127:0] ek;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        @(posedge clk);
        #1 aes_done = 1'b1;
        for (int i = 0; i < N; i++) aes_cipher[128*i +: 128] = rnd128();
        @(posedge clk);
        #1 aes_done = 1'b0;
        stray_req = 1'b0;
      end else if (!rst && aes_start) begin
        n_start++;
        last_start_cyc = cyc;
        in_flight = 1'b1;
        chk("batch_nonempty", bq_plain.size() != 0, 1);
        for (int i = 0; i < N; i++) begin
          ep = (i < bq_plain.size()) ? bq_plain[i] : 128'h0;
          ek = (i < bq_key.size())   ? bq_key[i]   : 128'h0;
          chk($sformatf("lane%0d_plain", i), aes_plain[128*i +: 128], ep);
          chk($sformatf("lane%0d_key", i), aes_key[128*i +: 128], ek);
          ct[i] = core_fn(aes_plain[128*i +: 128], aes_key[128*i +: 128]);
        end
        bq_plain.delete();
        bq_key.delete();
        cap_p = aes_plain;
        if (done_en) begin
          repeat (done_delay) @(posedge clk);
          #1;
          chk("plain_held", aes_plain == cap_p, 1);
          aes_done = 1'b1;
          for (int i = 0; i < N; i++) aes_cipher[128*i +: 128] = ct[i];
          @(posedge clk);
          #1 aes_done = 1'b0;
          in_flight = 1'b0;
        end else begin
          wait (timeout_err || rst);
          in_flight = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [TAG_W-1:0] t,
                      input bit fl, input int gap);
    int w;
    bit ok;
    exp_t e;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_plain = p;
    in_key   = k;
    in_tag   = t;
    flush    = fl;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 5000) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else w++;
    end
    @(posedge clk);
    #1;
    chk("send_accept", ok, 1);
    if (ok) begin
      e.tag = t;
      e.ct  = core_fn(p, k);
      sb.push_back(e);
      bq_plain.push_back(p);
      bq_key.push_back(k);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk(name, w < 5000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    int sz;
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_out", {out_tag, out_cipher}, 0);
    chk("rst_aes_plain", aes_plain == '0, 1);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: full FIPS batch
    s0 = n_start;
    for (int t = 0; t < N; t++) send(FIPS_PT, FIPS_KEY, TAG_W'(t), 1'b0, 0);
    wait_idle("t1_idle");
    chk("t1_starts", n_start - s0, 1);

    // 2: partial flush of 3
    s0 = n_start;
    for (int t = 0; t < 3; t++) send(rnd128(), rnd128(), TAG_W'(t), 1'b0, 0);
    flush_pulse();
    wait_idle("t2_idle");
    chk("t2_starts", n_start - s0, 1);

    // 3: flush with the 5th accept, then flush on an empty scheduler
    s0 = n_start;
    for (int t = 0; t < 5; t++) send(rnd128(), rnd128(), TAG_W'(t), t == 4, 0);
    wait_idle("t3_idle");
    chk("t3_starts", n_start - s0, 1);
    s0 = n_start;
    flush_pulse();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_empty_flush_starts", n_start - s0, 0);
    chk("t3_empty_flush_busy", busy, 0);

    // random partial batches with gaps: ordering across batches
    for (int b = 0; b < 4; b++) begin
      sz = $urandom_range(1, N);
      for (int t = 0; t < sz; t++)
        send(rnd128(), rnd128(), TAG_W'($urandom_range(0, 255)), (t == sz - 1) && (sz < N),
             $urandom_range(0, 2));
    end
    wait_idle("rand_idle");

    // 4: back-pressure
    rdy_pct = 30;
    for (int t = 0; t < N; t++) send(rnd128(), rnd128(), TAG_W'(t + 16), 1'b0, 0);
    wait_idle("t4_idle");
    rdy_pct = 100;

    // 5: watchdog abort
    done_en = 1'b0;
    s0 = n_start;
    for (int t = 0; t < N; t++) send(rnd128(), rnd128(), TAG_W'(t), 1'b0, 0);
    w = 0;
    while (n_start == s0 && w < 50) begin @(negedge clk); w++; end
    chk("t5_start_seen", n_start - s0, 1);
    w = 0;
    while (!timeout_err && w < 1200) begin @(negedge clk); w++; end
    chk("t5_timeout_latency", cyc - last_start_cyc, TIMEOUT + 1);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    done_en = 1'b1;
    stray_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_stray_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    chk("t5_stray_busy", busy, 0);
    chk("t5_err_sticky", timeout_err, 1);

    // 6: reset during drain after 4 outputs
    s0 = n_pop;
    for (int t = 0; t < N; t++) send(rnd128(), rnd128(), TAG_W'(t + 100), 1'b0, 0);
    w = 0;
    while (n_pop < s0 + 4 && w < 200) begin @(negedge clk); w++; end
    chk("t6_four_out", n_pop - s0, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out", {out_tag, out_cipher}, 0);
    chk("t6_timeout_err", timeout_err, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_busy_start", {busy, aes_start}, 0);
    chk("t6_lanes_zero", (aes_plain == '0) && (aes_key == '0), 1);
    sb.delete();
    bq_plain.delete();
    bq_key.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("t6_in_ready_release", in_ready, 1);
    s0 = n_start;
    for (int t = 0; t < N; t++) send(FIPS_PT, FIPS_KEY, TAG_W'(t), 1'b0, 0);
    wait_idle("t6_idle");
    chk("t6_starts", n_start - s0, 1);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
